// File: rtl/pulse_timer_if.sv
// Control/status bundle for pulse_timer: master drives controls, slave is the timer.
// With PULSE_TIMER_MATCH_EN defined, match_val and alarm are added.
interface pulse_timer_if #(
  parameter int CNT_W  = 32,
  parameter int TICK_W = 16
);
  logic              start;
  logic              stop;
  logic              clear;
  logic              oneshot;
  logic              period_ld;
  logic [CNT_W-1:0]  period_in;
  logic              tick;
  logic              running;
  logic              done;
  logic [CNT_W-1:0]  cycle_count;
  logic [TICK_W-1:0] tick_count;
  logic              tick_ovf;
`ifdef PULSE_TIMER_MATCH_EN
  logic [TICK_W-1:0] match_val;
  logic              alarm;

  modport master (
    output start, stop, clear, oneshot, period_ld, period_in, match_val,
    input  tick, running, done, cycle_count, tick_count, tick_ovf, alarm
  );
  modport slave (
    input  start, stop, clear, oneshot, period_ld, period_in, match_val,
    output tick, running, done, cycle_count, tick_count, tick_ovf, alarm
  );
`else
  modport master (
    output start, stop, clear, oneshot, period_ld, period_in,
    input  tick, running, done, cycle_count, tick_count, tick_ovf
  );
  modport slave (
    input  start, stop, clear, oneshot, period_ld, period_in,
    output tick, running, done, cycle_count, tick_count, tick_ovf
  );
`endif
endinterface

// File: rtl/pulse_timer.sv
// Periodic / one-shot interval timer emitting a registered one-cycle tick per period.
// Optional tick-count match alarm enabled by defining PULSE_TIMER_MATCH_EN.
module pulse_timer #(
  parameter int          CNT_W          = 32,
  parameter int          TICK_W         = 16,
  parameter int unsigned DEFAULT_PERIOD = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  pulse_timer_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
  localparam logic [TICK_W-1:0] TICK_ONE  = {{(TICK_W-1){1'b0}}, 1'b1};
  localparam logic [TICK_W-1:0] TICK_MAX  = {TICK_W{1'b1}};
  localparam logic [CNT_W-1:0]  RST_PERIOD =
    (DEFAULT_PERIOD == 32'd0) ? CNT_ONE : CNT_W'(DEFAULT_PERIOD);

  // A zero period would never reach terminal count, so it is treated as one cycle.
  function automatic logic [CNT_W-1:0] norm_period(input logic [CNT_W-1:0] p);
    if (p == CNT_ZERO) begin
      return CNT_ONE;
    end else begin
      return p;
    end
  endfunction

  logic [1:0]        state_r,   state_s;
  logic              mode_r,    mode_s;
  logic [CNT_W-1:0]  active_r,  active_s;
  logic [CNT_W-1:0]  pending_r, pending_s;
  logic [CNT_W-1:0]  cycle_r,   cycle_s;
  logic [TICK_W-1:0] tcnt_r,    tcnt_s;
  logic              done_r,    done_s;
  logic              ovf_r,     ovf_s;
  logic              tick_r,    tick_s;
  logic              running_r, running_s;
  logic              term_s;
  logic [TICK_W-1:0] tick_inc_s;
`ifdef PULSE_TIMER_MATCH_EN
  logic              alarm_r,   alarm_s;
`endif

  // Next-state and counter update; clear overrides counters, stop overrides start.
  always_comb begin
    state_s    = state_r;
    mode_s     = mode_r;
    active_s   = active_r;
    cycle_s    = cycle_r;
    tcnt_s     = tcnt_r;
    done_s     = done_r;
    ovf_s      = ovf_r;
    tick_s     = 1'b0;
    tick_inc_s = tcnt_r + TICK_ONE;
    term_s     = (cycle_r == (active_r - CNT_ONE));
`ifdef PULSE_TIMER_MATCH_EN
    alarm_s    = 1'b0;
`endif
    if (bus.period_ld) begin
      pending_s = norm_period(bus.period_in);
    end else begin
      pending_s = pending_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_s  = ST_RUN;
          mode_s   = bus.oneshot;
          active_s = pending_r;
          cycle_s  = CNT_ZERO;
          done_s   = 1'b0;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_s = ST_PAUSE;
        end else if (bus.clear) begin
          state_s = ST_RUN;
        end else if (term_s) begin
          cycle_s  = CNT_ZERO;
          tick_s   = 1'b1;
          tcnt_s   = tick_inc_s;
          active_s = pending_r;
          if (tcnt_r == TICK_MAX) begin
            ovf_s = 1'b1;
          end else begin
            ovf_s = ovf_r;
          end
`ifdef PULSE_TIMER_MATCH_EN
          alarm_s = (bus.match_val != TICK_ZERO) && (tick_inc_s == bus.match_val);
`endif
          if (mode_r) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          cycle_s = cycle_r + CNT_ONE;
        end
      end
      ST_PAUSE: begin
        if (bus.start && !bus.stop) begin
          state_s = ST_RUN;
          mode_s  = bus.oneshot;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (bus.clear) begin
      cycle_s = CNT_ZERO;
      tcnt_s  = TICK_ZERO;
      done_s  = 1'b0;
      ovf_s   = 1'b0;
      tick_s  = 1'b0;
    end else begin
      tick_s  = tick_s;
    end

    running_s = (state_s == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      mode_r    <= 1'b0;
      active_r  <= RST_PERIOD;
      pending_r <= RST_PERIOD;
      cycle_r   <= CNT_ZERO;
      tcnt_r    <= TICK_ZERO;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      mode_r    <= mode_s;
      active_r  <= active_s;
      pending_r <= pending_s;
      cycle_r   <= cycle_s;
      tcnt_r    <= tcnt_s;
      done_r    <= done_s;
      ovf_r     <= ovf_s;
      tick_r    <= tick_s;
      running_r <= running_s;
    end
  end

`ifdef PULSE_TIMER_MATCH_EN
  // Alarm register, pulses alongside tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_r <= 1'b0;
    end else begin
      alarm_r <= alarm_s;
    end
  end

  assign bus.alarm = alarm_r;
`endif

  assign bus.tick        = tick_r;
  assign bus.running     = running_r;
  assign bus.done        = done_r;
  assign bus.cycle_count = cycle_r;
  assign bus.tick_count  = tcnt_r;
  assign bus.tick_ovf    = ovf_r;

endmodule

// File: tb/tb_pulse_timer.sv
// Directed self-checking bench for pulse_timer with a 5-cycle default period and 4-bit tick counter.
module tb_pulse_timer;

  localparam int CNT_W  = 8;
  localparam int TICK_W = 4;

  logic clk;
  logic reset_n;
  int   vec_cnt;
  int   err_cnt;

  pulse_timer_if #(.CNT_W(CNT_W), .TICK_W(TICK_W)) bus ();

  pulse_timer #(.CNT_W(CNT_W), .TICK_W(TICK_W), .DEFAULT_PERIOD(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.oneshot = 1'b0;
    bus.period_ld = 1'b0; bus.period_in = 8'd0;
`ifdef PULSE_TIMER_MATCH_EN
    bus.match_val = 4'd0;
`endif
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++;
    if ({bus.tick, bus.running, bus.done, bus.tick_ovf} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_flags got=%b want=0000", {bus.tick, bus.running, bus.done, bus.tick_ovf});
    end
    vec_cnt++;
    if (bus.cycle_count !== 8'd0 || bus.tick_count !== 4'd0) begin
      err_cnt++;
      $display("FAIL reset_counts got cyc=%0d tcnt=%0d want 0 0", bus.cycle_count, bus.tick_count);
    end
  endtask

  task automatic test_periodic();
    do_reset();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    vec_cnt++;
    if (bus.running !== 1'b1 || bus.cycle_count !== 8'd0) begin
      err_cnt++;
      $display("FAIL periodic_start got run=%b cyc=%0d want 1 0", bus.running, bus.cycle_count);
    end
    for (int k = 1; k <= 15; k++) begin
      bus.start = (k == 3);  // start while running must be ignored
      step();
      vec_cnt++;
      if (bus.tick !== (k % 5 == 0) || bus.cycle_count !== 8'(k % 5) || bus.tick_count !== 4'(k / 5)) begin
        err_cnt++;
        $display("FAIL periodic_k%0d got tick=%b cyc=%0d tcnt=%0d want %b %0d %0d", k,
                 bus.tick, bus.cycle_count, bus.tick_count, (k % 5 == 0), k % 5, k / 5);
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_oneshot();
    int bad;
    do_reset();
    bus.oneshot = 1'b1; bus.start = 1'b1; step(); bus.start = 1'b0; bus.oneshot = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      vec_cnt++;
      if (bus.tick !== (k == 5)) begin
        err_cnt++;
        $display("FAIL oneshot_tick_k%0d got=%b want=%b", k, bus.tick, (k == 5));
      end
    end
    vec_cnt++;
    if ({bus.running, bus.done} !== 2'b01 || bus.cycle_count !== 8'd0 || bus.tick_count !== 4'd1) begin
      err_cnt++;
      $display("FAIL oneshot_end got run=%b done=%b cyc=%0d tcnt=%0d want 0 1 0 1",
               bus.running, bus.done, bus.cycle_count, bus.tick_count);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.tick !== 1'b0 || bus.running !== 1'b0) bad++;
    end
    vec_cnt++;
    if (bad !== 0) begin
      err_cnt++;
      $display("FAIL oneshot_quiet got %0d active cycles want 0", bad);
    end
    bus.start = 1'b1; step(); bus.start = 1'b0;
    vec_cnt++;
    if ({bus.running, bus.done} !== 2'b10) begin
      err_cnt++;
      $display("FAIL oneshot_restart got run=%b done=%b want 1 0", bus.running, bus.done);
    end
  endtask

  task automatic test_pause();
    int bad;
    do_reset();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step(); step(); step();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    vec_cnt++;
    if (bus.running !== 1'b0 || bus.cycle_count !== 8'd3) begin
      err_cnt++;
      $display("FAIL pause_enter got run=%b cyc=%0d want 0 3", bus.running, bus.cycle_count);
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.tick !== 1'b0 || bus.cycle_count !== 8'd3) bad++;
    end
    vec_cnt++;
    if (bad !== 0) begin
      err_cnt++;
      $display("FAIL pause_hold got %0d bad cycles want 0", bad);
    end
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step();
    vec_cnt++;
    if (bus.tick !== 1'b0 || bus.cycle_count !== 8'd4) begin
      err_cnt++;
      $display("FAIL pause_resume1 got tick=%b cyc=%0d want 0 4", bus.tick, bus.cycle_count);
    end
    step();
    vec_cnt++;
    if (bus.tick !== 1'b1 || bus.tick_count !== 4'd1 || bus.cycle_count !== 8'd0) begin
      err_cnt++;
      $display("FAIL pause_resume2 got tick=%b tcnt=%0d cyc=%0d want 1 1 0", bus.tick, bus.tick_count, bus.cycle_count);
    end
  endtask

  task automatic test_period_ld();
    logic exp_tick;
    do_reset();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      bus.period_ld = (k == 3 || k == 10);
      bus.period_in = (k == 3) ? 8'd3 : 8'd0;
      step();
      exp_tick = (k == 5 || k == 8 || k == 11 || k >= 12);
      vec_cnt++;
      if (bus.tick !== exp_tick) begin
        err_cnt++;
        $display("FAIL period_ld_k%0d got tick=%b want=%b", k, bus.tick, exp_tick);
      end
    end
    bus.period_ld = 1'b0;
    vec_cnt++;
    if (bus.cycle_count !== 8'd0) begin
      err_cnt++;
      $display("FAIL period_one_cyc got=%0d want=0", bus.cycle_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (k == 75) begin
        vec_cnt++;
        if (bus.tick_count !== 4'd15 || bus.tick_ovf !== 1'b0) begin
          err_cnt++;
          $display("FAIL wrap_pre got tcnt=%0d ovf=%b want 15 0", bus.tick_count, bus.tick_ovf);
        end
      end
    end
    vec_cnt++;
    if (bus.tick_count !== 4'd0 || bus.tick_ovf !== 1'b1 || bus.tick !== 1'b1) begin
      err_cnt++;
      $display("FAIL wrap_post got tcnt=%0d ovf=%b tick=%b want 0 1 1", bus.tick_count, bus.tick_ovf, bus.tick);
    end
    step(); step();
    bus.clear = 1'b1; step(); bus.clear = 1'b0;
    vec_cnt++;
    if (bus.tick_count !== 4'd0 || bus.tick_ovf !== 1'b0 || bus.running !== 1'b1 || bus.cycle_count !== 8'd0) begin
      err_cnt++;
      $display("FAIL wrap_clear got tcnt=%0d ovf=%b run=%b cyc=%0d want 0 0 1 0",
               bus.tick_count, bus.tick_ovf, bus.running, bus.cycle_count);
    end
    step();
    vec_cnt++;
    if (bus.cycle_count !== 8'd1) begin
      err_cnt++;
      $display("FAIL wrap_after_clear got cyc=%0d want 1", bus.cycle_count);
    end
  endtask

  task automatic test_clear_stop_term();
    do_reset();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step(); step(); step(); step();
    bus.clear = 1'b1; bus.stop = 1'b1; step(); bus.clear = 1'b0; bus.stop = 1'b0;
    vec_cnt++;
    if (bus.tick !== 1'b0 || bus.cycle_count !== 8'd0 || bus.tick_count !== 4'd0 || bus.running !== 1'b0) begin
      err_cnt++;
      $display("FAIL clear_stop_term got tick=%b cyc=%0d tcnt=%0d run=%b want 0 0 0 0",
               bus.tick, bus.cycle_count, bus.tick_count, bus.running);
    end
    step();
    vec_cnt++;
    if (bus.tick !== 1'b0 || bus.cycle_count !== 8'd0) begin
      err_cnt++;
      $display("FAIL clear_stop_paused got tick=%b cyc=%0d want 0 0", bus.tick, bus.cycle_count);
    end
  endtask

  task automatic test_priority();
    do_reset();
    bus.stop = 1'b1; bus.start = 1'b1; step(); bus.stop = 1'b0; bus.start = 1'b0;
    vec_cnt++;
    if (bus.running !== 1'b0) begin
      err_cnt++;
      $display("FAIL stop_start got run=%b want 0", bus.running);
    end
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step(); step();
    bus.clear = 1'b1; bus.start = 1'b1; step(); bus.clear = 1'b0; bus.start = 1'b0;
    vec_cnt++;
    if (bus.running !== 1'b1 || bus.cycle_count !== 8'd0) begin
      err_cnt++;
      $display("FAIL clear_start got run=%b cyc=%0d want 1 0", bus.running, bus.cycle_count);
    end
    for (int k = 1; k <= 5; k++) step();
    vec_cnt++;
    if (bus.tick !== 1'b1 || bus.tick_count !== 4'd1) begin
      err_cnt++;
      $display("FAIL clear_start_tick got tick=%b tcnt=%0d want 1 1", bus.tick, bus.tick_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int k = 1; k <= 7; k++) step();
    #2;
    reset_n = 1'b0;
    #1;
    vec_cnt++;
    if ({bus.tick, bus.running, bus.done, bus.tick_ovf} !== 4'b0000 ||
        bus.cycle_count !== 8'd0 || bus.tick_count !== 4'd0) begin
      err_cnt++;
      $display("FAIL async_reset got tick=%b run=%b done=%b ovf=%b cyc=%0d tcnt=%0d want all 0",
               bus.tick, bus.running, bus.done, bus.tick_ovf, bus.cycle_count, bus.tick_count);
    end
    step();
    reset_n = 1'b1;
    step();
    vec_cnt++;
    if (bus.running !== 1'b0 || bus.tick !== 1'b0) begin
      err_cnt++;
      $display("FAIL async_reset_idle got run=%b tick=%b want 0 0", bus.running, bus.tick);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_pause();
    test_period_ld();
    test_wrap();
    test_clear_stop_term();
    test_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pulse_timer.md
Name: pulse_timer

Overview:
- Parametrised periodic/one-shot interval timer; generalises the fixed 1-second pulse generator.
- Counts clk cycles up to a runtime-loadable period and emits a one-cycle tick at each terminal count.
- Accumulates elapsed ticks and supports start/stop/clear control plus a one-shot mode.
- Feeds seconds/interval strobes to display, debounce and watchdog logic in the same clock domain.

Parameters:
- CNT_W, 32, width of the cycle counter and period register.
- TICK_W, 16, width of the elapsed-tick counter.
- DEFAULT_PERIOD, 50000000, period in clk cycles after reset (1 s at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; arms the timer.
- stop  in  1  single-cycle pulse; pauses the timer and holds both counters.
- clear  in  1  single-cycle pulse; zeroes both counters and done; run state unchanged.
- oneshot  in  1  mode select, sampled only when start is accepted.
- period_ld  in  1  loads period_in into the pending period register.
- period_in  in  CNT_W  new period in cycles.
- tick  out  1  one-cycle pulse at terminal count.
- running  out  1  high while counting.
- done  out  1  sticky one-shot completion flag.
- cycle_count  out  CNT_W  current cycle counter.
- tick_count  out  TICK_W  elapsed ticks, wraps modulo 2^TICK_W.
- tick_ovf  out  1  sticky flag; set when tick_count wraps from all-ones to 0.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - running=0, done=0, tick=0, tick_ovf=0, cycle_count=0, tick_count=0, mode=periodic.
  - Active and pending period = DEFAULT_PERIOD.
- Period rules:
  - Period P means one tick every P cycles; terminal count is P-1.
  - A loaded value of 0 is stored as 1, so P=1 gives a tick every cycle.
- period_ld:
  - Writes the pending register.
  - Pending is copied to active when start is accepted while idle, and at every terminal count while running.
  - An in-flight interval is never shortened or stretched.
- States: IDLE, RUN, PAUSE.
  - IDLE --start--> RUN: latch mode, copy pending to active, cycle_count=0, done=0.
  - RUN --stop--> PAUSE: counters hold.
  - PAUSE --start--> RUN: resume from the held cycle_count; mode re-sampled; active period unchanged.
  - RUN in one-shot mode, at terminal count --> IDLE with done=1.
- Counting in RUN:
  - When cycle_count==P-1: cycle_count<=0, tick<=1 for exactly that one cycle (registered, so tick is visible the cycle after the compare), tick_count<=tick_count+1.
  - Otherwise cycle_count<=cycle_count+1, tick<=0.
- Latency:
  - First tick is asserted P cycles after the start-accept edge.
  - Subsequent ticks are exactly P cycles apart.
- Priority on simultaneous inputs: clear > stop > start.
  - clear+start: counters zeroed and run begins from 0.
  - stop+start: stop wins.
  - clear coinciding with terminal count: no tick, counters zeroed.
  - start while already RUN is ignored; it does not restart the interval.
- running = (state==RUN). tick is low in IDLE and PAUSE.
- tick_ovf is cleared only by clear or reset.
- Reset mid-operation aborts immediately with no tick.

Optional Feature:
- Macro: PULSE_TIMER_MATCH_EN.
- Defined:
  - Adds input match_val (TICK_W) and output alarm (1).
  - alarm pulses for one cycle, coincident with tick, when the incremented tick_count equals match_val.
  - alarm is reset to 0 and is suppressed when match_val==0.
- Undefined: no match_val or alarm ports, and no comparator logic.

Test Plan:
- Bench uses DEFAULT_PERIOD=5, TICK_W=4.
- Reset release, start pulse, periodic mode -> tick high exactly at cycles 5, 10, 15 after start; cycle_count sequence 0,1,2,3,4,0; tick_count 1,2,3.
- oneshot=1 with start -> single tick at cycle 5, then running=0, done=1, cycle_count=0; no further ticks for 20 cycles; next start clears done.
- Start, stop at cycle 3 (cycle_count=3), wait 10 cycles, start -> no tick while paused; tick 2 cycles after resume; tick_count=1.
- period_ld with period_in=3 at cycle 2 of a running period-5 interval -> next tick at cycle 5, following ticks at cycles 8 and 11; period_in=0 -> tick every cycle from the next interval.
- Run 16 ticks -> tick_count wraps from 15 to 0 and tick_ovf=1; clear -> tick_count=0, tick_ovf=0, running unchanged.
- clear and stop asserted together on the terminal-count cycle -> no tick, counters 0, state PAUSE. Separately, reset_n asserted mid-interval -> all outputs return to reset values asynchronously.
